// File: rtl/midi_note_decoder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : midi_note_decoder_pkg                                              |
// | Brief  : Shared types and constants for the MIDI note decoder: the         |
// |          oscillator control word, MIDI status nibbles, system/realtime     |
// |          thresholds, message kinds and parser state encoding.              |
// | Rev    : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
package midi_note_decoder_pkg;

  // Control word handed to the oscillator.
  typedef struct packed {
    logic [6:0] note;
    logic [6:0] velocity;
    logic       note_en;
  } dsp_to_osc_t;

  // Channel-voice status nibbles (upper nibble of a status byte).
  localparam logic [3:0] ST_NOTE_OFF = 4'h8;
  localparam logic [3:0] ST_NOTE_ON  = 4'h9;
  localparam logic [3:0] ST_POLY_AT  = 4'hA;
  localparam logic [3:0] ST_CTRL     = 4'hB;
  localparam logic [3:0] ST_PROG     = 4'hC;
  localparam logic [3:0] ST_CHAN_AT  = 4'hD;
  localparam logic [3:0] ST_PITCH    = 4'hE;

  // F0..F7 are system common/exclusive, F8..FF are realtime.
  localparam logic [7:0] SYSTEM_MIN   = 8'hF0;
  localparam logic [7:0] REALTIME_MIN = 8'hF8;

  typedef enum logic [2:0] {
    MK_NONE     = 3'd0,
    MK_NOTE_OFF = 3'd1,
    MK_NOTE_ON  = 3'd2,
    MK_SKIP1    = 3'd3,
    MK_SKIP2    = 3'd4
  } midi_kind_t;

  // Parser states: D1 = waiting for first data byte, D2 = waiting for second.
  localparam logic [1:0] PS_IDLE = 2'd0;
  localparam logic [1:0] PS_D1   = 2'd1;
  localparam logic [1:0] PS_D2   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/midi_note_decoder_byte_classify.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : midi_note_decoder_byte_classify                                    |
// | Brief  : Combinational classification of one MIDI byte.                     |
// |   byte_in      in  8  raw MIDI byte                                          |
// |   midi_channel in  4  receive channel                                       |
// |   is_realtime  out 1  F8..FF                                                |
// |   is_system    out 1  F0..F7                                                |
// |   is_status    out 1  80..EF channel-voice status                            |
// |   kind         out    message kind of a status byte (MK_NONE otherwise)     |
// |   chan_match   out 1  status channel accepted (always 1 when OMNI != 0)     |
// | Rev    : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
module midi_note_decoder_byte_classify
  import midi_note_decoder_pkg::*;
#(
  parameter int OMNI = 0
) (
  input  logic [7:0]  byte_in,
  input  logic [3:0]  midi_channel,
  output logic        is_realtime,
  output logic        is_system,
  output logic        is_status,
  output midi_kind_t  kind,
  output logic        chan_match
);

  always_comb begin
    is_realtime = (byte_in >= REALTIME_MIN);
    is_system   = (byte_in >= SYSTEM_MIN) && !is_realtime;
    is_status   = byte_in[7] && (byte_in < SYSTEM_MIN);
    chan_match  = (OMNI != 0) || (byte_in[3:0] == midi_channel);
    kind        = MK_NONE;
    if (is_status) begin
      case (byte_in[7:4])
        ST_NOTE_OFF:                    kind = MK_NOTE_OFF;
        ST_NOTE_ON:                     kind = MK_NOTE_ON;
        ST_POLY_AT, ST_CTRL, ST_PITCH:  kind = MK_SKIP2;
        ST_PROG, ST_CHAN_AT:            kind = MK_SKIP1;
        default:                        kind = MK_NONE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/midi_note_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : midi_note_decoder                                                  |
// | Brief  : Parses a raw MIDI byte stream into a monophonic note/velocity/     |
// |          note_en word for the oscillator. Running status, channel filter,  |
// |          realtime bytes, velocity-0 Note On and optional retrigger gap.    |
// |   clk          in   1  system clock                                         |
// |   reset        in   1  synchronous, active-low reset                        |
// |   midi_channel in   4  receive channel (ignored when OMNI != 0)             |
// |   byte_in      in   8  MIDI byte from UART receiver                         |
// |   byte_valid   in   1  byte_in valid                                        |
// |   byte_ready   out  1  byte accepted when byte_valid & byte_ready           |
// |   dsp_to_osc   out     {note, velocity, note_en}                            |
// |   note_event   out  1  one-cycle pulse when a message changes dsp_to_osc   |
// | Rev    : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
module midi_note_decoder
  import midi_note_decoder_pkg::*;
#(
  parameter int RETRIG  = 1,
  parameter int OMNI    = 0,
  parameter int NOTE_LO = 21,
  parameter int NOTE_HI = 108
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  midi_channel,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output dsp_to_osc_t dsp_to_osc,
  output logic        note_event
);

  localparam logic [6:0] KEY_LO = 7'(NOTE_LO);
  localparam logic [6:0] KEY_HI = 7'(NOTE_HI);

  logic        is_realtime, is_system, is_status, chan_match;
  midi_kind_t  kind;

  logic [1:0]  pstate, pstate_nxt;
  midi_kind_t  rs_kind, rs_kind_nxt;
  logic        rs_match, rs_match_nxt;
  logic [6:0]  d1, d1_nxt;
  logic        msg_done;

  // gap is high for the single cycle in which a retriggered note is held off.
  logic        gap, gap_nxt;
  dsp_to_osc_t osc_nxt;
  logic        event_nxt;
  logic        accept;
  logic [6:0]  key, vel;
  logic        do_on, do_off;

  midi_note_decoder_byte_classify #(.OMNI(OMNI)) u_classify (
    .byte_in      (byte_in),
    .midi_channel (midi_channel),
    .is_realtime  (is_realtime),
    .is_system    (is_system),
    .is_status    (is_status),
    .kind         (kind),
    .chan_match   (chan_match)
  );

  assign byte_ready = ~gap;
  assign accept     = byte_valid & byte_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      pstate     <= PS_IDLE;
      rs_kind    <= MK_NONE;
      rs_match   <= 1'b0;
      d1         <= 7'd0;
      gap        <= 1'b0;
      dsp_to_osc <= '{note: KEY_LO, velocity: 7'd0, note_en: 1'b0};
      note_event <= 1'b0;
    end else begin
      pstate     <= pstate_nxt;
      rs_kind    <= rs_kind_nxt;
      rs_match   <= rs_match_nxt;
      d1         <= d1_nxt;
      gap        <= gap_nxt;
      dsp_to_osc <= osc_nxt;
      note_event <= event_nxt;
    end
  end

  // Parser next state. Realtime bytes leave everything untouched.
  always_comb begin
    pstate_nxt   = pstate;
    rs_kind_nxt  = rs_kind;
    rs_match_nxt = rs_match;
    d1_nxt       = d1;
    msg_done     = 1'b0;
    if (accept && !is_realtime) begin
      if (is_system) begin
        rs_kind_nxt = MK_NONE;
        pstate_nxt  = PS_IDLE;
      end else if (is_status) begin
        rs_kind_nxt  = kind;
        rs_match_nxt = chan_match;
        pstate_nxt   = PS_D1;
      end else begin
        case (pstate)
          // A data byte in IDLE under running status is a first data byte.
          PS_IDLE, PS_D1: begin
            if (rs_kind == MK_SKIP1) begin
              pstate_nxt = PS_IDLE;
              msg_done   = 1'b1;
            end else if (rs_kind != MK_NONE) begin
              d1_nxt     = byte_in[6:0];
              pstate_nxt = PS_D2;
            end
          end
          PS_D2: begin
            pstate_nxt = PS_IDLE;
            msg_done   = 1'b1;
          end
          default: pstate_nxt = PS_IDLE;
        endcase
      end
    end
  end

  // Output next values
  assign key = d1;
  assign vel = byte_in[6:0];
  assign do_on  = msg_done && rs_match && (rs_kind == MK_NOTE_ON) && (vel != 7'd0) &&
                  (key >= KEY_LO) && (key <= KEY_HI);
  assign do_off = msg_done && rs_match && dsp_to_osc.note_en && (key == dsp_to_osc.note) &&
                  ((rs_kind == MK_NOTE_OFF) || ((rs_kind == MK_NOTE_ON) && (vel == 7'd0)));

  always_comb begin
    osc_nxt   = dsp_to_osc;
    event_nxt = 1'b0;
    gap_nxt   = 1'b0;
    if (gap) begin
      // No byte is accepted during the gap, so no message can compete here.
      osc_nxt.note_en = 1'b1;
    end else if (do_on) begin
      osc_nxt.note     = key;
      osc_nxt.velocity = vel;
      event_nxt        = 1'b1;
      if ((RETRIG != 0) && dsp_to_osc.note_en) begin
        osc_nxt.note_en = 1'b0;
        gap_nxt         = 1'b1;
      end else begin
        osc_nxt.note_en = 1'b1;
      end
    end else if (do_off) begin
      osc_nxt.note_en = 1'b0;
      event_nxt       = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_midi_note_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_midi_note_decoder                                               |
// | Brief  : Self-checking bench; a message-level model of the decoder is      |
// |          compared to two DUTs (channel-filtered and OMNI) every cycle,     |
// |          plus literal expectations after directed byte sequences.          |
// | Rev    : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
module tb_midi_note_decoder;
  import midi_note_decoder_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  midi_channel = 4'd0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        rdy0, rdy1, ev0, ev1;
  dsp_to_osc_t osc0, osc1;

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  midi_note_decoder #(.RETRIG(1), .OMNI(0)) dut (
    .clk(clk), .reset(reset), .midi_channel(midi_channel), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(rdy0), .dsp_to_osc(osc0), .note_event(ev0));

  midi_note_decoder #(.RETRIG(1), .OMNI(1)) dut_omni (
    .clk(clk), .reset(reset), .midi_channel(midi_channel), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(rdy1), .dsp_to_osc(osc1), .note_event(ev1));

  // Message-level reference: running status byte, count of data bytes
  // collected so far, and the visible outputs.
  typedef struct packed {
    logic [7:0] rs;
    logic       have_d0;
    logic [6:0] d0;
    logic [6:0] note;
    logic [6:0] vel;
    logic       en;
    logic       ev;
    logic       gap;
  } ms_t;

  function automatic ms_t reset_state();
    ms_t s;
    s = '0;
    s.note = 7'd21;
    return s;
  endfunction

  function automatic ms_t step(ms_t s, logic rst_n, logic v, logic [7:0] b, bit omni);
    ms_t n;
    int  len;
    int  k, vv;
    bit  match;
    n = s;
    n.ev = 1'b0;
    if (!rst_n) return reset_state();
    if (s.gap) begin
      n.gap = 1'b0;
      n.en  = 1'b1;
      return n;
    end
    if (!v || b >= 8'hF8) return n;
    if (b >= 8'hF0) begin
      n.rs = 8'h00; n.have_d0 = 1'b0;
    end else if (b[7]) begin
      n.rs = b; n.have_d0 = 1'b0;
    end else if (s.rs != 8'h00) begin
      len = (s.rs[7:4] == 4'hC || s.rs[7:4] == 4'hD) ? 1 : 2;
      if (len == 2 && !s.have_d0) begin
        n.d0 = b[6:0]; n.have_d0 = 1'b1;
      end else begin
        n.have_d0 = 1'b0;
        match = omni || (s.rs[3:0] == midi_channel);
        k  = int'(s.d0);
        vv = int'(b[6:0]);
        if (len == 2 && match) begin
          if (s.rs[7:4] == 4'h9 && vv > 0) begin
            if (k >= 21 && k <= 108) begin
              n.note = s.d0; n.vel = b[6:0]; n.ev = 1'b1;
              if (s.en) begin n.en = 1'b0; n.gap = 1'b1; end
              else n.en = 1'b1;
            end
          end else if (s.rs[7:4] == 4'h8 || s.rs[7:4] == 4'h9) begin
            if (s.en && s.d0 == s.note) begin n.en = 1'b0; n.ev = 1'b1; end
          end
        end
      end
    end
    return n;
  endfunction

  ms_t m0, m1;
  initial begin m0 = reset_state(); m1 = reset_state(); end

  always @(posedge clk) begin
    m0 <= step(m0, reset, byte_valid, byte_in, 1'b0);
    m1 <= step(m1, reset, byte_valid, byte_in, 1'b1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("osc",       32'(osc0), 32'({m0.note, m0.vel, m0.en}));
      chk("event",     32'(ev0),  32'(m0.ev));
      chk("ready",     32'(rdy0), 32'(!m0.gap));
      chk("omni_osc",  32'(osc1), 32'({m1.note, m1.vel, m1.en}));
      chk("omni_event",32'(ev1),  32'(m1.ev));
      chk("omni_ready",32'(rdy1), 32'(!m1.gap));
    end
  end

  function automatic logic [31:0] lit(int n, int v, int e);
    return 32'({7'(n), 7'(v), 1'(e)});
  endfunction

  // Drive one byte for one cycle; return just after the edge that took it.
  task automatic send1(input logic [7:0] b);
    byte_in = b; byte_valid = 1'b1;
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] b);
    send1(b);
    idle();
  endtask

  task automatic msg(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send(a); send(b); send(c);
  endtask

  initial begin
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    started = 1'b1;
    chk("reset_osc",   32'(osc0), lit(21, 0, 0));
    chk("reset_ready", 32'(rdy0), 32'd1);

    // 1: basic note on, event pulse on the cycle after the last byte
    send(8'h90); send(8'h3C); send1(8'h64);
    chk("t1_osc",   32'(osc0), lit(60, 100, 1));
    chk("t1_event", 32'(ev0),  32'd1);
    idle();
    chk("t1_event_end", 32'(ev0), 32'd0);

    // 2: running-status legato note -> retrigger gap
    send(8'h40); send1(8'h50);
    chk("t2_gap_osc",   32'(osc0), lit(64, 80, 0));
    chk("t2_gap_ready", 32'(rdy0), 32'd0);
    idle();
    chk("t2_osc",   32'(osc0), lit(64, 80, 1));
    chk("t2_ready", 32'(rdy0), 32'd1);

    // 3: off for a different key ignored, vel-0 on clears note_en
    msg(8'h90, 8'h3C, 8'h64);
    msg(8'h80, 8'h40, 8'h00);
    chk("t3_off_other", 32'(osc0), lit(60, 100, 1));
    msg(8'h90, 8'h3C, 8'h00);
    chk("t3_vel0", 32'(osc0), lit(60, 100, 0));

    // 4: realtime bytes interleaved
    send(8'h90); send(8'hF8); send(8'h3C); send(8'hF8); send(8'h64);
    chk("t4_rt", 32'(osc0), lit(60, 100, 1));
    msg(8'h80, 8'h3C, 8'h00);
    chk("t4_off", 32'(osc0), lit(60, 100, 0));

    // 5: other channel: filtered vs OMNI
    msg(8'h91, 8'h3D, 8'h20);
    chk("t5_filtered", 32'(osc0), lit(60, 100, 0));
    chk("t5_omni",     32'(osc1), lit(61, 32, 1));

    // 6: out-of-range keys, program change skip, range boundaries
    msg(8'h90, 8'h10, 8'h64);
    chk("t6_key16", 32'(osc0), lit(60, 100, 0));
    send(8'hC0); send(8'h05); msg(8'h90, 8'h3C, 8'h64);
    chk("t6_pc", 32'(osc0), lit(60, 100, 1));
    msg(8'h90, 8'h6D, 8'h40);
    chk("t6_key109", 32'(osc0), lit(60, 100, 1));
    msg(8'h90, 8'h6C, 8'h40); idle();
    chk("t6_key108", 32'(osc0), lit(108, 64, 1));
    msg(8'h90, 8'h15, 8'h41); idle();
    chk("t6_key21", 32'(osc0), lit(21, 65, 1));
    msg(8'h90, 8'h14, 8'h42);
    chk("t6_key20", 32'(osc0), lit(21, 65, 1));
    // system byte clears running status: following data dropped
    send(8'hF0); send(8'h3C); send(8'h00);
    chk("t6_sys", 32'(osc0), lit(21, 65, 1));

    // reset in the middle of a message, with a byte offered at the same edge
    send(8'h90); send(8'h3C);
    reset = 1'b0; byte_in = 8'h90; byte_valid = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1; byte_valid = 1'b0;
    chk("t6_reset_osc", 32'(osc0), lit(21, 0, 0));
    send(8'h64); send(8'h3C); send(8'h64);
    chk("t6_drop", 32'(osc0), lit(21, 0, 0));
    chk("t6_drop_ev", 32'(ev0), 32'd0);

    idle(); idle();
    started = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
